pipe_ctrl_n: RTL

PIPE_CTRL_N -- requirements
Module: pipe_ctrl_n

---
 rtl/pipe_ctrl_n.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_n.sv
// In-order execute pipeline controller: tracks NUM_STAGES stages, merges late-unit results,
// resolves RAW dependencies by forwarding or hazard, and handles retire, squash and flush.
module pipe_ctrl_n #(
    parameter int NUM_STAGES = 3,
    parameter int LATE_STAGE = 2,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic        issue_rd_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        issue_late_i,
    input  logic [31:0] issue_pc_i,
    input  logic [31:0] issue_result_i,
    input  logic [5:0]  issue_exception_i,
    input  logic [4:0]  src_ra_i,
    input  logic [4:0]  src_rb_i,
    output logic        fwd_ra_hit_o,
    output logic        fwd_rb_hit_o,
    output logic [31:0] fwd_ra_o,
    output logic [31:0] fwd_rb_o,
    output logic        hazard_o,
    input  logic        late_complete_i,
    input  logic [31:0] late_result_i,
    input  logic [5:0]  late_exception_i,
    input  logic        flush_i,
    output logic        valid_wb_o,
    output logic [4:0]  rd_wb_o,
    output logic [31:0] result_wb_o,
    output logic [31:0] pc_wb_o,
    output logic [5:0]  exception_wb_o,
    output logic        stall_o,
    output logic        squash_o
);
    typedef struct packed {
        logic        valid;
        logic        rd_valid;
        logic [4:0]  rd;
        logic        late;
        logic        ready;
        logic [31:0] pc;
        logic [31:0] result;
        logic [5:0]  exception;
    } stage_t;

    stage_t stage_q  [1:NUM_STAGES];
    stage_t stage_d  [1:NUM_STAGES];
    stage_t shift_in [1:NUM_STAGES];
    stage_t issue_entry;
    stage_t late_merged;

    logic                late_pending;
    logic                late_resolve;
    logic                issue_fire;
    logic [NUM_STAGES:1] fwd_live;
    logic [4:0]          src_idx [2];

    // Late-unit merge point: an unresolved late op here freezes everything until it completes.
    assign late_pending = stage_q[LATE_STAGE].valid & stage_q[LATE_STAGE].late
                        & ~stage_q[LATE_STAGE].ready;
    assign late_resolve = late_pending & late_complete_i;
    assign stall_o      = late_pending & ~late_complete_i;

    always_comb begin
        late_merged = stage_q[LATE_STAGE];
        if (late_resolve) begin
            late_merged.result = late_result_i;
            late_merged.ready  = 1'b1;
            if (late_merged.exception == 6'd0) begin
                late_merged.exception = late_exception_i;
            end
        end
    end

    assign issue_fire = issue_valid_i & issue_ready_o;

    always_comb begin
        issue_entry = '0;
        if (issue_fire) begin
            issue_entry.valid     = 1'b1;
            issue_entry.rd_valid  = issue_rd_valid_i;
            issue_entry.rd        = issue_rd_i;
            issue_entry.late      = issue_late_i;
            issue_entry.ready     = ~issue_late_i;
            issue_entry.pc        = issue_pc_i;
            issue_entry.result    = issue_result_i;
            issue_entry.exception = issue_exception_i;
        end
    end

    assign shift_in[1] = issue_entry;

    for (genvar gi = 2; gi <= NUM_STAGES; gi++) begin : g_shift
        if (gi - 1 == LATE_STAGE) begin : g_late
            assign shift_in[gi] = late_merged;
        end else begin : g_plain
            assign shift_in[gi] = stage_q[gi-1];
        end
    end

    // Squash can only occur when not stalled, so it never competes with the hold path.
    always_comb begin
        for (int s = 1; s <= NUM_STAGES; s++) begin
            stage_d[s] = stage_q[s];
            if (flush_i || squash_o) begin
                stage_d[s] = '0;
            end else if (!stall_o) begin
                stage_d[s] = shift_in[s];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 1; s <= NUM_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= NUM_STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    for (genvar gi = 1; gi <= NUM_STAGES; gi++) begin : g_live
        assign fwd_live[gi] = stage_q[gi].valid & stage_q[gi].rd_valid
                            & (stage_q[gi].exception == 6'd0);
    end

    assign src_idx[0] = src_ra_i;
    assign src_idx[1] = src_rb_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic        hit;
        logic        haz;
        logic [31:0] val;
        // Walk oldest to youngest so the youngest matching stage has the final say.
        always_comb begin
            hit = 1'b0;
            haz = 1'b0;
            val = '0;
            for (int s = NUM_STAGES; s >= 1; s--) begin
                if (src_idx[gi] != 5'd0 && fwd_live[s] && stage_q[s].rd == src_idx[gi]) begin
                    hit = FWD_EN & stage_q[s].ready;
                    haz = ~(FWD_EN & stage_q[s].ready);
                    val = (FWD_EN & stage_q[s].ready) ? stage_q[s].result : 32'd0;
                end
            end
        end
    end

    assign fwd_ra_hit_o = g_fwd[0].hit;
    assign fwd_rb_hit_o = g_fwd[1].hit;
    assign fwd_ra_o     = g_fwd[0].val;
    assign fwd_rb_o     = g_fwd[1].val;
    assign hazard_o     = g_fwd[0].haz | g_fwd[1].haz;

    assign issue_ready_o = ~stall_o & ~squash_o & ~flush_i & ~hazard_o;

    assign valid_wb_o     = stage_q[NUM_STAGES].valid & ~stall_o;
    assign rd_wb_o        = (valid_wb_o && stage_q[NUM_STAGES].rd_valid
                             && stage_q[NUM_STAGES].exception == 6'd0)
                            ? stage_q[NUM_STAGES].rd : 5'd0;
    assign squash_o       = valid_wb_o & (stage_q[NUM_STAGES].exception != 6'd0);
    assign result_wb_o    = stage_q[NUM_STAGES].result;
    assign pc_wb_o        = stage_q[NUM_STAGES].pc;
    assign exception_wb_o = stage_q[NUM_STAGES].exception;

endmodule
